// File: rtl/wb_queue.sv
// Writeback queue: merges two result producers into the regfile's single write port, in arrival order.
// Optional WB_QUEUE_FORWARD_EN adds a combinational lookup of pending writes (newest first).
module wb_queue #(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 64,
   parameter  int QDEPTH = 4,
   localparam int AW     = $clog2(DEPTH),
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [AW-1:0]    s0_reg,
   input  logic [WIDTH-1:0] s0_data,
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic [AW-1:0]    s1_reg,
   input  logic [WIDTH-1:0] s1_data,
   output logic             wb_we,
   output logic [AW-1:0]    wb_reg,
   output logic [WIDTH-1:0] wb_data,
   output logic [CW-1:0]    q_count,
   input  logic [AW-1:0]    fwd_addr,
   output logic             fwd_hit,
   output logic [WIDTH-1:0] fwd_data
);

   logic [AW-1:0]    q_reg  [QDEPTH];
   logic [WIDTH-1:0] q_data [QDEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    wr_ptr1;
   logic [CW-1:0]    count;
   logic             enq0;
   logic             enq1;
   logic             pop;

   // Source 1 may only enqueue when two slots are free, so a double accept never overflows.
   assign s0_ready = (count <= CW'(QDEPTH - 1));
   assign s1_ready = (count <= CW'(QDEPTH - 2));
   assign q_count  = count;

   // r0 writes complete the handshake but are dropped: regfile hardwires r0.
   assign enq0    = s0_valid && s0_ready && (s0_reg != '0);
   assign enq1    = s1_valid && s1_ready && (s1_reg != '0);
   assign pop     = (count != '0);
   assign wr_ptr1 = wr_ptr + PW'(enq0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         wb_we   <= 1'b0;
         wb_reg  <= '0;
         wb_data <= '0;
      end else begin
         if (enq0) begin
            q_reg[wr_ptr]  <= s0_reg;
            q_data[wr_ptr] <= s0_data;
         end
         if (enq1) begin
            q_reg[wr_ptr1]  <= s1_reg;
            q_data[wr_ptr1] <= s1_data;
         end
         wr_ptr <= wr_ptr + PW'(enq0) + PW'(enq1);
         wb_we  <= pop;
         if (pop) begin
            wb_reg  <= q_reg[rd_ptr];
            wb_data <= q_data[rd_ptr];
            rd_ptr  <= rd_ptr + PW'(1);
         end
         count <= count + CW'(enq0) + CW'(enq1) - CW'(pop);
      end
   end

`ifdef WB_QUEUE_FORWARD_EN
   // Scan oldest to newest so later matches override earlier ones; the output register is oldest of all.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fwd_addr != '0) begin
         if (wb_we && (wb_reg == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data;
         end
         for (int i = 0; i < QDEPTH; i++) begin
            if ((CW'(i) < count) && (q_reg[rd_ptr + PW'(i)] == fwd_addr)) begin
               fwd_hit  = 1'b1;
               fwd_data = q_data[rd_ptr + PW'(i)];
            end
         end
      end
   end
`else
   logic fwd_unused;
   assign fwd_unused = ^fwd_addr;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule
